mac_seq_ctrl: RTL

Sequencer that drives one fixed-point multiply-accumulate unit (`p = a*b + c`, N-bit, Q fractional bits, registered, gated by `ce`) to compute a biased dot product of a streamed vector. The block accepts a job (length, bias), pulls operand pairs over a ready/valid stream, and feeds each MAC result back as the next `c` input. It presents the final accumulator on a ready/valid output. It sits between the operand source (testbench or upstream buffer) and the MAC instance, and owns the MAC's `ce`, `a`, `b` and `c` inputs.

---
 rtl/mac_seq_ctrl.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/mac_seq_ctrl.sv
// Purpose: sequences one registered MAC (p = a*b + c) through a biased dot product of a streamed vector.
// Latency: len*(MAC_LAT+2)+1 cycles from start to out_valid_o (1 cycle for len==0); one pair per MAC_LAT+2 cycles.
// Backpressure: stalls in ISSUE while in_valid_i is low; holds out_data_o/out_valid_o until out_ready_i.
//
// Ports:
//   clk_i, rst_ni                  clock, asynchronous active-low reset
//   start_i, len_i, bias_i         job request (sampled in IDLE only)
//   clr_i                          synchronous abort to IDLE, highest priority
//   in_valid_i/in_ready_o, in_a_i, in_b_i    operand-pair stream
//   mac_ce_o, mac_a_o, mac_b_o, mac_c_o, mac_p_i   MAC instance control and result
//   out_valid_o/out_ready_i, out_data_o      final accumulator
//   busy_o                         high whenever not in IDLE
module mac_seq_ctrl #(
    parameter int N       = 16,
    parameter int Q       = 12,
    parameter int LEN_W   = 8,
    parameter int MAC_LAT = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic [LEN_W-1:0] len_i,
    input  logic [N-1:0]     bias_i,
    input  logic             clr_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [N-1:0]     in_a_i,
    input  logic [N-1:0]     in_b_i,
    output logic             mac_ce_o,
    output logic [N-1:0]     mac_a_o,
    output logic [N-1:0]     mac_b_o,
    output logic [N-1:0]     mac_c_o,
    input  logic [N-1:0]     mac_p_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [N-1:0]     out_data_o,
    output logic             busy_o
);

    localparam int WC_W = (MAC_LAT > 0) ? $clog2(MAC_LAT + 1) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           state_q;
    logic [N-1:0]     acc_q;
    logic [LEN_W-1:0] cnt_q;
    logic [WC_W-1:0]  wcnt_q;
    logic             in_ready_q;
    logic             mac_ce_q;
    logic [N-1:0]     mac_a_q;
    logic [N-1:0]     mac_b_q;
    logic [N-1:0]     mac_c_q;
    logic             out_valid_q;
    logic [N-1:0]     out_data_q;
    logic             busy_q;

    // Q only describes the MAC's number format; the controller never interprets it.
    logic unused_q;
    assign unused_q = (Q > 0);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            wcnt_q      <= '0;
            in_ready_q  <= 1'b0;
            mac_ce_q    <= 1'b0;
            mac_a_q     <= '0;
            mac_b_q     <= '0;
            mac_c_q     <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            busy_q      <= 1'b0;
        end else if (clr_i) begin
            // Abort beats start and every handshake; out_data keeps the last result.
            state_q     <= IDLE;
            in_ready_q  <= 1'b0;
            mac_ce_q    <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        acc_q  <= bias_i;
                        cnt_q  <= len_i;
                        busy_q <= 1'b1;
                        if (len_i == '0) begin
                            state_q     <= DONE;
                            out_data_q  <= bias_i;
                            out_valid_q <= 1'b1;
                        end else begin
                            state_q    <= ISSUE;
                            in_ready_q <= 1'b1;
                            mac_ce_q   <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    // The MAC keeps re-evaluating the held operands here, which leaves p unchanged.
                    if (in_valid_i && in_ready_q) begin
                        mac_a_q    <= in_a_i;
                        mac_b_q    <= in_b_i;
                        mac_c_q    <= acc_q;
                        cnt_q      <= cnt_q - LEN_W'(1);
                        in_ready_q <= 1'b0;
                        wcnt_q     <= WC_W'(MAC_LAT);
                        state_q    <= WAIT;
                    end
                end
                WAIT: begin
                    // Counting down from MAC_LAT makes WAIT span MAC_LAT+1 cycles.
                    if (wcnt_q == '0) begin
                        acc_q <= mac_p_i;
                        if (cnt_q != '0) begin
                            state_q    <= ISSUE;
                            in_ready_q <= 1'b1;
                        end else begin
                            state_q     <= DONE;
                            out_data_q  <= mac_p_i;
                            out_valid_q <= 1'b1;
                            mac_ce_q    <= 1'b0;
                        end
                    end else begin
                        wcnt_q <= wcnt_q - WC_W'(1);
                    end
                end
                DONE: begin
                    if (out_ready_i) begin
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign in_ready_o  = in_ready_q;
    assign mac_ce_o    = mac_ce_q;
    assign mac_a_o     = mac_a_q;
    assign mac_b_o     = mac_b_q;
    assign mac_c_o     = mac_c_q;
    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    assign busy_o      = busy_q;

endmodule
